// File: rtl/seq_rec_trig_core.sv
// Sequence recorder with circular capture buffer, pre-trigger history and selectable trigger.
// Captured words are read back over the 8-bit bus oldest-first, MSB byte first within a word.
module seq_rec_trig_core #(
  parameter int MEM_BYTES = 8192,
  parameter int ABUSWIDTH = 16,
  parameter int IN_BITS   = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic [IN_BITS-1:0]   SEQ_IN,
  input  logic                 SEQ_EXT_START,
  output logic                 DONE
);
  localparam int NB    = IN_BITS / 8;
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(NB);
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

  logic [IN_BITS-1:0] mem [DEPTH];

  state_t      state, state_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n, trig_addr, trig_addr_n;
  logic [16:0] pre_cnt, pre_cnt_n, post_cnt, post_cnt_n;
  logic [16:0] pre_e, pre_e_n, post_e, post_e_n;
  logic        triggered, triggered_n, we;
  logic [2:0]  conf;
  logic [15:0] post_count, pre_count, trig16;
  logic        ext_d, ext_hit, trig, armed;
  logic [16:0] post17, pre17, room, post_calc, pre_calc;

  logic        is_reg, is_mem, soft_rst, arm, sw_trig;
  logic [3:0]  reg_sel;
  logic [31:0] boff, bsel;
  logic [AW-1:0] start_addr, rd_phys;
  logic [IN_BITS-1:0] rd_word;
  logic [7:0]  rd_byte, reg_byte;

  assign reg_sel  = BUS_ADD[3:0];
  assign is_reg   = (BUS_ADD[ABUSWIDTH-1:4] == '0);
  assign soft_rst = BUS_WR && is_reg && (reg_sel == 4'd0);
  assign arm      = BUS_WR && is_reg && (reg_sel == 4'd1);
  assign sw_trig  = BUS_WR && is_reg && (reg_sel == 4'd7);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      conf       <= '0;
      post_count <= 16'(DEPTH);
      pre_count  <= '0;
    end else if (BUS_WR && is_reg) begin
      case (reg_sel)
        4'd2: conf              <= BUS_DATA_IN[2:0];
        4'd3: post_count[7:0]   <= BUS_DATA_IN;
        4'd4: post_count[15:8]  <= BUS_DATA_IN;
        4'd5: pre_count[7:0]    <= BUS_DATA_IN;
        4'd6: pre_count[15:8]   <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  // Effective counts: post window wins, history gets whatever room remains.
  always_comb begin
    post17    = {1'b0, post_count};
    post_calc = (post17 > DEPTH17) ? DEPTH17 : post17;
    room      = DEPTH17 - post_calc;
    pre17     = {1'b0, pre_count};
    pre_calc  = (pre17 > room) ? room : pre17;
  end

  assign ext_hit = conf[1] ? SEQ_EXT_START : (SEQ_EXT_START & ~ext_d);
  assign trig    = sw_trig | conf[2] | (conf[0] & ext_hit);

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    pre_cnt_n   = pre_cnt;
    post_cnt_n  = post_cnt;
    trig_addr_n = trig_addr;
    triggered_n = triggered;
    pre_e_n     = pre_e;
    post_e_n    = post_e;
    we          = 1'b0;
    if (soft_rst) begin
      state_n     = S_IDLE;
      wr_ptr_n    = '0;
      pre_cnt_n   = '0;
      post_cnt_n  = '0;
      trig_addr_n = '0;
      triggered_n = 1'b0;
      pre_e_n     = '0;
      post_e_n    = '0;
    end else if (arm) begin
      state_n     = S_FILL;
      wr_ptr_n    = '0;
      pre_cnt_n   = '0;
      post_cnt_n  = '0;
      triggered_n = 1'b0;
      pre_e_n     = pre_calc;
      post_e_n    = post_calc;
    end else begin
      case (state)
        S_FILL: begin
          we        = 1'b1;
          wr_ptr_n  = wr_ptr + AW'(1);
          pre_cnt_n = pre_cnt + 17'd1;
          if (pre_cnt_n >= pre_e) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (trig) begin
            trig_addr_n = wr_ptr;
            triggered_n = 1'b1;
            if (post_e == 17'd0) begin
              state_n = S_DONE;
            end else begin
              we         = 1'b1;
              wr_ptr_n   = wr_ptr + AW'(1);
              post_cnt_n = 17'd1;
              state_n    = (post_e == 17'd1) ? S_DONE : S_POST;
            end
          end else begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + AW'(1);
          end
        end
        S_POST: begin
          we         = 1'b1;
          wr_ptr_n   = wr_ptr + AW'(1);
          post_cnt_n = post_cnt + 17'd1;
          if (post_cnt_n == post_e) state_n = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      triggered <= 1'b0;
      pre_e     <= '0;
      post_e    <= '0;
      ext_d     <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      pre_cnt   <= pre_cnt_n;
      post_cnt  <= post_cnt_n;
      trig_addr <= trig_addr_n;
      triggered <= triggered_n;
      pre_e     <= pre_e_n;
      post_e    <= post_e_n;
      ext_d     <= SEQ_EXT_START;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (we) mem[wr_ptr] <= SEQ_IN;
  end

  assign DONE   = (state == S_DONE);
  assign armed  = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
  assign trig16 = 16'(trig_addr);

  // Readout is rotated so bus offset 0 maps to the oldest pre-trigger sample.
  always_comb begin
    boff       = 32'(BUS_ADD) - 32'd16;
    is_mem     = (32'(BUS_ADD) >= 32'd16) && (boff < 32'(MEM_BYTES));
    start_addr = trig_addr - pre_e[AW-1:0];
    rd_phys    = start_addr + AW'(boff >> BW);
    rd_word    = mem[rd_phys];
    bsel       = 32'(NB - 1) - (boff & 32'(NB - 1));
    rd_byte    = 8'(rd_word >> (bsel * 32'd8));
  end

  always_comb begin
    reg_byte = 8'd0;
    case (reg_sel)
      4'd0: reg_byte = 8'd1;
      4'd1: reg_byte = {5'b0, triggered, armed, DONE};
      4'd2: reg_byte = {5'b0, conf};
      4'd3: reg_byte = post_count[7:0];
      4'd4: reg_byte = post_count[15:8];
      4'd5: reg_byte = pre_count[7:0];
      4'd6: reg_byte = pre_count[15:8];
      4'd8: reg_byte = trig16[7:0];
      4'd9: reg_byte = trig16[15:8];
      default: reg_byte = 8'd0;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      BUS_DATA_OUT <= 8'd0;
    end else if (soft_rst) begin
      BUS_DATA_OUT <= 8'd0;
    end else if (BUS_RD) begin
      BUS_DATA_OUT <= is_reg ? reg_byte : (is_mem ? rd_byte : 8'd0);
    end
  end
endmodule

// File: tb/tb_seq_rec_trig_core.sv
// Bench for seq_rec_trig_core: 8-bit/64-byte instance (a) and 16-bit/64-byte instance (b).
module tb_seq_rec_trig_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_add, b_add;
  logic [7:0]  a_din, b_din, a_dout, b_dout;
  logic        a_rd, a_wr, b_rd, b_wr, a_ext, b_ext, a_done, b_done;
  logic [7:0]  a_seq;
  logic [15:0] b_seq;

  seq_rec_trig_core #(.MEM_BYTES(64), .ABUSWIDTH(16), .IN_BITS(8)) dut_a (
    .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(a_add), .BUS_DATA_IN(a_din),
    .BUS_RD(a_rd), .BUS_WR(a_wr), .BUS_DATA_OUT(a_dout),
    .SEQ_IN(a_seq), .SEQ_EXT_START(a_ext), .DONE(a_done));

  seq_rec_trig_core #(.MEM_BYTES(64), .ABUSWIDTH(16), .IN_BITS(16)) dut_b (
    .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(b_add), .BUS_DATA_IN(b_din),
    .BUS_RD(b_rd), .BUS_WR(b_wr), .BUS_DATA_OUT(b_dout),
    .SEQ_IN(b_seq), .SEQ_EXT_START(b_ext), .DONE(b_done));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp;
  } rvec_t;
  rvec_t tbl[11];

  // Free-running sample counter, changes on the falling edge.
  initial begin
    a_seq = 8'd0;
    forever begin
      @(negedge clk);
      a_seq = a_seq + 8'd1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(int which, logic [15:0] ad, logic [7:0] d);
    if (which == 0) begin a_add = ad; a_din = d; a_wr = 1'b1; end
    else            begin b_add = ad; b_din = d; b_wr = 1'b1; end
    step();
    a_wr = 1'b0;
    b_wr = 1'b0;
  endtask

  task automatic rd(int which, logic [15:0] ad, logic [7:0] exp, string nm);
    logic [7:0] got;
    if (which == 0) begin a_add = ad; a_rd = 1'b1; end
    else            begin b_add = ad; b_rd = 1'b1; end
    exp_q.push_back(exp);
    step();
    a_rd = 1'b0;
    b_rd = 1'b0;
    got = (which == 0) ? a_dout : b_dout;
    chk(nm, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_done(int which, int maxc, string nm);
    int n = 0;
    while (((which == 0) ? a_done : b_done) !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk(nm, 32'((which == 0) ? a_done : b_done), 32'd1);
  endtask

  task automatic reg_table(string tag);
    for (int i = 0; i < 11; i++)
      rd(0, tbl[i].addr, tbl[i].exp, $sformatf("%s_reg%0d", tag, tbl[i].addr));
  endtask

  initial begin
    logic [7:0] tv, s0;
    int n;
    tbl[0]  = '{16'd0,  8'h01};
    tbl[1]  = '{16'd1,  8'h00};
    tbl[2]  = '{16'd2,  8'h00};
    tbl[3]  = '{16'd3,  8'h40};
    tbl[4]  = '{16'd4,  8'h00};
    tbl[5]  = '{16'd5,  8'h00};
    tbl[6]  = '{16'd6,  8'h00};
    tbl[7]  = '{16'd7,  8'h00};
    tbl[8]  = '{16'd8,  8'h00};
    tbl[9]  = '{16'd9,  8'h00};
    tbl[10] = '{16'd12, 8'h00};

    a_add = '0; a_din = '0; a_rd = 0; a_wr = 0; a_ext = 0;
    b_add = '0; b_din = '0; b_rd = 0; b_wr = 0; b_ext = 0; b_seq = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_dout", 32'(a_dout), 32'd0);
    reg_table("rst");
    rd(1, 16'd3, 8'h20, "b_rst_post_lo");
    rd(0, 16'd3, 8'h40, "hold_pre");
    step();
    chk("dout_hold", 32'(a_dout), 32'h40);

    // Edge-mode external trigger, PRE=4 POST=8
    wr(0, 5, 8'd4); wr(0, 6, 8'd0); wr(0, 3, 8'd8); wr(0, 4, 8'd0);
    wr(0, 2, 8'h01);
    wr(0, 1, 8'h00);
    repeat (6) step();
    n = 0;
    while (a_seq != 8'h40 && n < 300) begin step(); n++; end
    chk("t2_sync", 32'(a_seq), 32'h40);
    a_ext = 1'b1;
    step();
    a_ext = 1'b0;
    repeat (6) step();
    chk("t2_done_early", 32'(a_done), 32'd0);
    step();
    chk("t2_done_rise", 32'(a_done), 32'd1);
    for (int j = 0; j < 12; j++)
      rd(0, 16'(16 + j), 8'(8'h3C + j), $sformatf("t2_buf%0d", j));
    rd(0, 16'd1, 8'h05, "t2_status");

    // Async reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("t1_done_async", 32'(a_done), 32'd0);
    chk("t1_dout_async", 32'(a_dout), 32'd0);
    #1;
    rst = 1'b0;
    step();
    reg_table("t1");

    // Trigger ignored during FILL, accepted in WAIT
    wr(0, 5, 8'd10); wr(0, 6, 8'd0); wr(0, 3, 8'd8); wr(0, 4, 8'd0);
    wr(0, 2, 8'h01);
    wr(0, 1, 8'h00);
    step(); step();
    a_ext = 1'b1;
    step();
    a_ext = 1'b0;
    repeat (16) step();
    tv = a_seq;
    a_ext = 1'b1;
    step();
    a_ext = 1'b0;
    wait_done(0, 40, "t3_done");
    rd(0, 16'd8, 8'd19, "t3_trig_lo");
    rd(0, 16'd9, 8'd0, "t3_trig_hi");
    for (int j = 0; j < 18; j++)
      rd(0, 16'(16 + j), 8'(tv - 8'd10 + 8'(j)), $sformatf("t3_buf%0d", j));

    // Held-high external input: edge mode never fires, level mode fires at once
    a_ext = 1'b1;
    wr(0, 5, 8'd2); wr(0, 6, 8'd0); wr(0, 3, 8'd8); wr(0, 4, 8'd0);
    wr(0, 2, 8'h01);
    step();
    wr(0, 1, 8'h00);
    repeat (100) step();
    chk("t4_edge_done", 32'(a_done), 32'd0);
    rd(0, 16'd1, 8'h02, "t4_edge_status");
    wr(0, 2, 8'h03);
    wr(0, 1, 8'h00);
    s0 = a_seq;
    wait_done(0, 40, "t4_level_done");
    rd(0, 16'd8, 8'd2, "t4_trig_lo");
    for (int j = 0; j < 10; j++)
      rd(0, 16'(16 + j), 8'(s0 + 8'(j)), $sformatf("t4_buf%0d", j));
    a_ext = 1'b0;

    // Wrapped buffer with clamped history, then soft reset in POST
    wr(0, 5, 8'd60); wr(0, 6, 8'd0); wr(0, 3, 8'd10); wr(0, 4, 8'd0);
    wr(0, 2, 8'h00);
    wr(0, 1, 8'h00);
    repeat (80) step();
    tv = a_seq;
    wr(0, 7, 8'h00);
    wait_done(0, 40, "t5_done");
    rd(0, 16'd8, 8'd16, "t5_trig_lo");
    for (int j = 0; j < 64; j++)
      rd(0, 16'(16 + j), 8'(tv - 8'd54 + 8'(j)), $sformatf("t5_buf%0d", j));
    wr(0, 1, 8'h00);
    repeat (60) step();
    wr(0, 7, 8'h00);
    step(); step();
    rd(0, 16'd1, 8'h06, "t5_status_post");
    wr(0, 0, 8'h00);
    chk("t5_srst_done", 32'(a_done), 32'd0);
    chk("t5_srst_dout", 32'(a_dout), 32'd0);
    repeat (12) step();
    chk("t5_srst_stay", 32'(a_done), 32'd0);
    rd(0, 16'd1, 8'h00, "t5_srst_status");
    rd(0, 16'd3, 8'd10, "t5_post_kept");
    rd(0, 16'd5, 8'd60, "t5_pre_kept");

    // 16-bit samples, PRE=0, MSB byte first
    wr(1, 3, 8'd2); wr(1, 4, 8'd0);
    wr(1, 1, 8'h00);
    repeat (4) step();
    b_seq = 16'hA1B2;
    wr(1, 7, 8'h00);
    b_seq = 16'hC3D4;
    step();
    b_seq = 16'h0000;
    wait_done(1, 10, "t6_done");
    rd(1, 16'd8, 8'd4, "t6_trig_lo");
    rd(1, 16'd16, 8'hA1, "t6_b16");
    rd(1, 16'd17, 8'hB2, "t6_b17");
    rd(1, 16'd18, 8'hC3, "t6_b18");
    rd(1, 16'd19, 8'hD4, "t6_b19");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
